idct_8x8: RTL and testbench

- 8x8 two-dimensional inverse DCT engine on the decode side of the hardware codec.
- Accepts one 64-coefficient block serially and reconstructs 64 8-bit pixels.
- Computes X = C^T * Y * C with one time-shared multiply-accumulate unit, as a column pass then a row pass.
- Streams pixels out with valid/ready backpressure, feeding the frame reassembly stage.

---
 rtl/idct_8x8.sv | 236 +++++++++++++++++++++++
 tb/tb_idct_8x8.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/idct_8x8.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | idct_8x8 : serial 8x8 2-D inverse DCT, one time-shared MAC, column pass    |
// |            then row pass, valid/ready pixel output.                        |
// | Optional : IDCT_DC_FASTPATH_EN enables a 2-cycle path for DC-only blocks.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module idct_8x8 #(
  parameter int COEF_W = 12,
  parameter int FRAC_W = 14,
  parameter int MID_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int c_ROM_W  = FRAC_W + 2;
  localparam int c_PROD_W = MID_W + c_ROM_W;
  localparam int c_ACC_W  = MID_W + FRAC_W + 5;
  // The cosine table is held in Q14; other fraction widths are rescaled from it.
  localparam int c_UP     = (FRAC_W >= 14) ? (FRAC_W - 14) : 0;
  localparam int c_DN     = (FRAC_W < 14) ? (14 - FRAC_W) : 0;
  localparam int c_DN_RND = (c_DN > 0) ? (1 << (c_DN - 1)) : 0;

  localparam logic signed [c_ACC_W-1:0] c_HALF =
    {{(c_ACC_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic signed [c_ACC_W-1:0] c_MID_MAX =
    {{(c_ACC_W-MID_W+1){1'b0}}, {(MID_W-1){1'b1}}};
  localparam logic signed [c_ACC_W-1:0] c_MID_MIN = ~c_MID_MAX;
  localparam logic signed [c_ACC_W-1:0] c_PIX_OFS = c_ACC_W'(128);
  localparam logic signed [c_ACC_W-1:0] c_PIX_MAX = c_ACC_W'(255);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_PASS1 = 3'd1,
    S_PASS2 = 3'd2,
    S_OUT   = 3'd3,
    S_DC1   = 3'd4,
    S_DC2   = 3'd5
  } state_t;

  state_t                     r_state, w_state_next;
  logic [5:0]                 r_idx, r_oidx;
  logic [8:0]                 r_cnt;
  logic signed [c_ACC_W-1:0]  r_acc;

  logic signed [COEF_W-1:0]   r_coef_buf [64];
  logic signed [MID_W-1:0]    r_t_buf    [64];
  logic [7:0]                 r_pix_buf  [64];

  logic                       w_in_fire, w_out_fire, w_pass;
  logic [2:0]                 w_k, w_mid, w_hi;
  logic signed [MID_W-1:0]    w_mul_a;
  logic signed [c_ROM_W-1:0]  w_mul_b;
  logic signed [c_PROD_W-1:0] w_prod;
  logic signed [c_ACC_W-1:0]  w_prod_ext, w_acc_base, w_acc_next, w_rnd, w_pval;
  logic signed [MID_W-1:0]    w_sat;
  logic [7:0]                 w_pix;

`ifdef IDCT_DC_FASTPATH_EN
  logic                       r_ac_nz;
  logic signed [MID_W-1:0]    r_dc_t;
`endif

  // C[u][x] = round(c(u) * cos((2x+1)*u*pi/16) * 2^FRAC_W)
  function automatic logic signed [c_ROM_W-1:0] cos_rom(input logic [2:0] u,
                                                        input logic [2:0] x);
    int m, k, q14, v;
    logic neg;
    m = ((2 * int'(x) + 1) * int'(u)) % 32;
    if (m <= 8) begin
      k = m; neg = 1'b0;
    end else if (m <= 16) begin
      k = 16 - m; neg = 1'b1;
    end else if (m <= 24) begin
      k = m - 16; neg = 1'b1;
    end else begin
      k = 32 - m; neg = 1'b0;
    end
    case (k)
      0:       q14 = 8192;
      1:       q14 = 8035;
      2:       q14 = 7568;
      3:       q14 = 6811;
      4:       q14 = 5793;
      5:       q14 = 4551;
      6:       q14 = 3135;
      7:       q14 = 1598;
      default: q14 = 0;
    endcase
    if (u == 3'd0) begin
      q14 = 5793;
      neg = 1'b0;
    end
    if (neg) q14 = -q14;
    if (c_DN == 0) v = q14 <<< c_UP;
    else           v = (q14 + c_DN_RND) >>> c_DN;
    return c_ROM_W'(v);
  endfunction

  assign in_ready   = (r_state == S_LOAD);
  assign out_valid  = (r_state == S_OUT);
  assign out_data   = out_valid ? r_pix_buf[r_oidx] : 8'd0;
  assign out_last   = out_valid && (r_oidx == 6'd63);
  assign busy       = (r_state != S_LOAD);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;
  assign w_pass     = (r_state == S_PASS1) || (r_state == S_PASS2);

  // cnt = {row/outer index, column index, MAC step}
  assign w_hi  = r_cnt[8:6];
  assign w_mid = r_cnt[5:3];
  assign w_k   = r_cnt[2:0];

  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    case (r_state)
      S_PASS1: begin
        w_mul_a = MID_W'(r_coef_buf[{w_k, w_mid}]);
        w_mul_b = cos_rom(w_k, w_hi);
      end
      S_PASS2: begin
        w_mul_a = r_t_buf[{w_hi, w_k}];
        w_mul_b = cos_rom(w_k, w_mid);
      end
`ifdef IDCT_DC_FASTPATH_EN
      S_DC1: begin
        w_mul_a = MID_W'(r_coef_buf[0]);
        w_mul_b = cos_rom(3'd0, 3'd0);
      end
      S_DC2: begin
        w_mul_a = r_dc_t;
        w_mul_b = cos_rom(3'd0, 3'd0);
      end
`endif
      default: ;
    endcase
  end

  // Counter is zero outside the passes, so the DC states also start a fresh sum.
  assign w_prod     = w_mul_a * w_mul_b;
  assign w_prod_ext = c_ACC_W'(w_prod);
  assign w_acc_base = (w_k == 3'd0) ? '0 : r_acc;
  assign w_acc_next = w_acc_base + w_prod_ext;
  assign w_rnd      = (w_acc_next + c_HALF) >>> FRAC_W;
  assign w_pval     = w_rnd + c_PIX_OFS;

  always_comb begin
    if (w_rnd > c_MID_MAX)      w_sat = c_MID_MAX[MID_W-1:0];
    else if (w_rnd < c_MID_MIN) w_sat = c_MID_MIN[MID_W-1:0];
    else                        w_sat = w_rnd[MID_W-1:0];
    if (w_pval[c_ACC_W-1])      w_pix = 8'd0;
    else if (w_pval > c_PIX_MAX) w_pix = 8'd255;
    else                        w_pix = w_pval[7:0];
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_LOAD: begin
        if (w_in_fire && (r_idx == 6'd63)) begin
`ifdef IDCT_DC_FASTPATH_EN
          w_state_next = (!r_ac_nz && (in_data == '0)) ? S_DC1 : S_PASS1;
`else
          w_state_next = S_PASS1;
`endif
        end
      end
      S_PASS1: if (r_cnt == 9'd511) w_state_next = S_PASS2;
      S_PASS2: if (r_cnt == 9'd511) w_state_next = S_OUT;
`ifdef IDCT_DC_FASTPATH_EN
      S_DC1:   w_state_next = S_DC2;
      S_DC2:   w_state_next = S_OUT;
`endif
      S_OUT:   if (w_out_fire && (r_oidx == 6'd63)) w_state_next = S_LOAD;
      default: w_state_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_LOAD;
      r_idx   <= '0;
      r_oidx  <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_in_fire)  r_idx  <= r_idx + 6'd1;
      if (w_out_fire) r_oidx <= r_oidx + 6'd1;
      if (w_pass) begin
        r_cnt <= r_cnt + 9'd1;
        r_acc <= w_acc_next;
      end
    end
  end

`ifdef IDCT_DC_FASTPATH_EN
  // r_ac_nz: some coefficient 1..62 of the current block was non-zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ac_nz <= 1'b0;
      r_dc_t  <= '0;
    end else begin
      if (w_in_fire) begin
        if (r_idx == 6'd0)        r_ac_nz <= 1'b0;
        else if (in_data != '0)   r_ac_nz <= 1'b1;
      end
      if (r_state == S_DC1) r_dc_t <= w_sat;
    end
  end
`endif

  // Buffers carry no reset: each entry is written before it is read.
  always_ff @(posedge clk) begin
    if (w_in_fire) r_coef_buf[r_idx] <= in_data;
    if ((r_state == S_PASS1) && (w_k == 3'd7)) r_t_buf[{w_hi, w_mid}] <= w_sat;
    if ((r_state == S_PASS2) && (w_k == 3'd7)) r_pix_buf[{w_hi, w_mid}] <= w_pix;
`ifdef IDCT_DC_FASTPATH_EN
    if (r_state == S_DC2) begin
      for (int n = 0; n < 64; n++) r_pix_buf[n] <= w_pix;
    end
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_idct_8x8.sv
`default_nettype none
// Testbench for idct_8x8: scoreboard of expected pixels, reference IDCT model.
module tb_idct_8x8;
  localparam int COEF_W   = 12;
  localparam int FRAC_W   = 14;
  localparam int MID_W    = 16;
  localparam int FULL_LAT = 1024;
`ifdef IDCT_DC_FASTPATH_EN
  localparam int DC_LAT = 2;
`else
  localparam int DC_LAT = 1024;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [COEF_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [7:0]        out_data;
  logic              out_last;
  logic              busy;

  idct_8x8 #(.COEF_W(COEF_W), .FRAC_W(FRAC_W), .MID_W(MID_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         rom [8][8];
  int         blk [64];
  int         e_cyc = 0;
  logic [7:0] exp_q [$];

  function automatic void build_rom();
    real c;
    for (int u = 0; u < 8; u++)
      for (int x = 0; x < 8; x++) begin
        c = (u == 0) ? $sqrt(0.125) : 0.5;
        rom[u][x] = int'($floor(c * $cos((2 * x + 1) * u * 3.14159265358979 / 16.0)
                                * 16384.0 + 0.5));
      end
  endfunction

  function automatic void model_push();
    longint t [8][8];
    longint acc, r;
    for (int i = 0; i < 8; i++)
      for (int v = 0; v < 8; v++) begin
        acc = 0;
        for (int u = 0; u < 8; u++) acc += longint'(rom[u][i]) * longint'(blk[8*u+v]);
        r = (acc + 8192) >>> 14;
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        t[i][v] = r;
      end
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        acc = 0;
        for (int v = 0; v < 8; v++) acc += t[i][v] * longint'(rom[v][j]);
        r = ((acc + 8192) >>> 14) + 128;
        if (r < 0) r = 0;
        else if (r > 255) r = 255;
        exp_q.push_back(8'(r));
      end
  endfunction

  function automatic void set_dc(input int dc);
    for (int n = 0; n < 64; n++) blk[n] = 0;
    blk[0] = dc;
  endfunction

  function automatic void push_const(input int p);
    for (int n = 0; n < 64; n++) exp_q.push_back(8'(p));
  endfunction

  // Drives ncoef coefficients of blk with random in_valid gaps; optional junk afterwards.
  task automatic send_block(input int gap_pct, input int ncoef, input bit junk);
    int n = 0;
    int guard = 0;
    while (n < ncoef && guard < 4000) begin
      @(negedge clk);
      guard++;
      if ($urandom_range(99) < gap_pct) in_valid = 1'b0;
      else begin
        in_valid = 1'b1;
        in_data  = COEF_W'(blk[n]);
        if (in_ready) begin
          if (n == 63) e_cyc = cyc + 1;
          n++;
        end
      end
    end
    if (n < ncoef) begin
      n_tests++; n_fail++;
      $display("FAIL load_timeout: accepted %0d coefficients, required %0d", n, ncoef);
    end
    @(negedge clk);
    in_valid = junk;
    in_data  = COEF_W'($urandom);
  endtask

  task automatic collect(input int ready_pct, input int lat_exp, input string name);
    int         got = 0;
    int         guard = 0;
    bit         seen = 0;
    bit         hold = 0;
    logic [7:0] held_d, exp;
    logic       held_l;
    n_tests++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_flags %s: busy=%b in_ready=%b, required 1 0", name, busy, in_ready);
    end
    while (got < 64 && guard < 6000) begin
      @(negedge clk);
      guard++;
      if (out_valid === 1'b1) begin
        if (!seen) begin
          seen = 1;
          in_valid = 1'b0;
          n_tests++;
          if (cyc - e_cyc != lat_exp) begin
            n_fail++;
            $display("FAIL latency %s: %0d cycles, required %0d", name, cyc - e_cyc, lat_exp);
          end
        end
        if (hold) begin
          n_tests++;
          if (out_data !== held_d || out_last !== held_l) begin
            n_fail++;
            $display("FAIL hold %s[%0d]: data=%0d last=%b, required %0d %b",
                     name, got, out_data, out_last, held_d, held_l);
          end
        end
        out_ready = ($urandom_range(99) < ready_pct);
        if (out_ready) begin
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          n_tests++;
          if (out_data !== exp || out_last !== (got == 63)) begin
            n_fail++;
            $display("FAIL pixel %s[%0d]: data=%0d last=%b, required %0d %b",
                     name, got, out_data, out_last, exp, (got == 63));
          end
          got++;
          hold = 0;
        end else begin
          hold = 1; held_d = out_data; held_l = out_last;
        end
      end else begin
        if (seen) begin
          n_tests++; n_fail++;
          $display("FAIL valid_drop %s[%0d]: out_valid=%b, required 1", name, got, out_valid);
          hold = 0;
        end
        out_ready = ($urandom_range(99) < ready_pct);
      end
    end
    if (got < 64) begin
      n_tests++; n_fail++;
      $display("FAIL out_timeout %s: %0d pixels, required 64", name, got);
    end
    @(negedge clk);
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_load %s: out_valid=%b in_ready=%b busy=%b, required 0 1 0",
               name, out_valid, in_ready, busy);
    end
  endtask

  task automatic check_reset_state(input string name);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 ||
        out_data !== 8'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: in_ready=%b out_valid=%b out_last=%b out_data=%0d busy=%b, required 1 0 0 0 0",
               name, in_ready, out_valid, out_last, out_data, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("reset_state");
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_block();
    set_dc(0);
    push_const(128);
    send_block(0, 64, 1'b1);
    collect(100, DC_LAT, "zero");
  endtask

  task automatic test_dc_values();
    set_dc(80);    push_const(138); send_block(0, 64, 1'b0); collect(100, DC_LAT, "dc80");
    set_dc(2047);  push_const(255); send_block(0, 64, 1'b0); collect(100, DC_LAT, "dc2047");
    set_dc(-1024); push_const(0);   send_block(0, 64, 1'b0); collect(100, DC_LAT, "dcm1024");
  endtask

  task automatic test_random();
    int ranges [3] = '{2047, 300, 40};
    for (int b = 0; b < 3; b++) begin
      for (int n = 0; n < 64; n++)
        blk[n] = int'($urandom_range(2 * ranges[b])) - ranges[b];
      blk[1] = (blk[1] == 0) ? 1 : blk[1];
      model_push();
      send_block(30, 64, 1'b1);
      collect(25, FULL_LAT, "random");
    end
  endtask

  task automatic test_abort();
    int seen_valid = 0;
    // abort during LOAD after 30 coefficients
    for (int n = 0; n < 64; n++) blk[n] = int'($urandom_range(400)) - 200;
    send_block(0, 30, 1'b0);
    #2 rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check_reset_state("abort_load_state");
    rst = 1'b0;
    // abort during PASS2
    blk[1] = 5;
    send_block(0, 64, 1'b0);
    repeat (600) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check_reset_state("abort_pass2_state");
    rst = 1'b0;
    repeat (1100) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen_valid++;
    end
    n_tests++;
    if (seen_valid != 0) begin
      n_fail++;
      $display("FAIL abort_no_output: %0d valid cycles, required 0", seen_valid);
    end
    set_dc(80);
    push_const(138);
    send_block(0, 64, 1'b0);
    collect(100, DC_LAT, "after_abort");
  endtask

  initial begin
    build_rom();
    test_reset();
    test_zero_block();
    test_dc_values();
    test_random();
    test_abort();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: %0d pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
